uart_rx_core: RTL

Parametrised UART receiver core. Integrates the line synchroniser, oversampling edge/bit counters, the frame state machine, the deserialiser and the parity/stop/break checks in one block. Supports 5–9 data bits, even or odd parity, and 1 or 2 stop bits. Sits between the pad-side serial input and the register/FIFO layer, and reports each received character with a one-cycle valid pulse and per-frame error flags.

---
 rtl/uart_rx_core.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: line sync, framing FSM, deserialiser, parity/stop/break checks.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around the bit centre.
module uart_rx_core #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  two_stop,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  brk,
  output logic                  busy
);

  localparam int BCNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  function automatic logic f_parity(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                r_state;
  state_t                w_next;

  logic                  r_sync1;
  logic                  r_rxs;
  logic                  r_rxs_d;

  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_par_en;
  logic                  r_par_odd;
  logic                  r_two_stop;

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BCNT_W-1:0]     r_bit_cnt;
  logic                  r_samp_mid;

  logic [DATA_W-1:0]     r_shift;
  logic                  r_glitch;
  logic                  r_par_pend;
  logic                  r_frm_pend;
  logic                  r_brk_pend;

  logic [DATA_W-1:0]     r_rx_data;
  logic                  r_rx_valid;
  logic                  r_par_err;
  logic                  r_frm_err;
  logic                  r_brk;
  logic                  r_busy;

  logic [PRESCALE_W-1:0] w_mid;
  logic [PRESCALE_W-1:0] w_mid_p1;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_dec;
  logic                  w_end;
  logic                  w_fall;
  logic                  w_bit;
  logic                  w_frm_final;
  logic                  w_brk_final;

  logic                  w_start;
  logic                  w_shift_en;
  logic                  w_par_chk;
  logic                  w_stop1_chk;
  logic                  w_stop2_chk;
  logic                  w_complete;
  logic                  w_glitch_set;

  // Two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_mid    = r_presc >> 1;
  assign w_mid_p1 = w_mid + 1'b1;
  assign w_last   = r_presc - 1'b1;
  assign w_dec    = (r_edge_cnt == w_mid_p1);
  assign w_end    = (r_edge_cnt == w_last);
  assign w_fall   = r_rxs_d & ~r_rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_mid <= 1'b1;
    end else if (r_edge_cnt == w_mid) begin
      r_samp_mid <= r_rxs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [PRESCALE_W-1:0] w_mid_m1;
  logic                  r_samp_lo;

  function automatic logic f_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_mid_m1 = w_mid - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_lo <= 1'b1;
    end else if (r_edge_cnt == w_mid_m1) begin
      r_samp_lo <= r_rxs;
    end
  end

  // Third vote is the live sample at mid+1, which is also the decision cycle
  assign w_bit = f_majority(r_samp_lo, r_samp_mid, r_rxs);
`else
  assign w_bit = r_samp_mid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START:  if (w_end) w_next = r_glitch ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_end && (r_bit_cnt == BCNT_W'(DATA_W))) begin
          w_next = r_par_en ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: if (w_end) w_next = S_STOP1;
      S_STOP1: begin
        if (r_two_stop) begin
          if (w_end) w_next = S_STOP2;
        end else if (w_dec) begin
          w_next = S_IDLE;
        end
      end
      S_STOP2:  if (w_dec) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start      = 1'b0;
    w_shift_en   = 1'b0;
    w_par_chk    = 1'b0;
    w_stop1_chk  = 1'b0;
    w_stop2_chk  = 1'b0;
    w_glitch_set = 1'b0;
    case (r_state)
      S_IDLE:   w_start      = w_fall;
      S_START:  w_glitch_set = w_dec & w_bit;
      S_DATA:   w_shift_en   = w_dec;
      S_PARITY: w_par_chk    = w_dec;
      S_STOP1:  w_stop1_chk  = w_dec;
      S_STOP2:  w_stop2_chk  = w_dec;
      default: ;
    endcase
    // Completion happens at the last stop-bit decision, leaving the rest of the bit for resync
    w_complete = (w_stop1_chk & ~r_two_stop) | w_stop2_chk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (w_start) begin
      r_presc    <= prescale;
      r_par_en   <= par_en;
      r_par_odd  <= par_odd;
      r_two_stop <= two_stop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if ((r_state == S_IDLE) || w_end) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Frame shadow state; break candidacy survives only while every sampled bit is 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_glitch   <= 1'b0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_start) begin
      r_shift    <= '0;
      r_glitch   <= 1'b0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
      r_brk_pend <= 1'b1;
    end else begin
      if (w_glitch_set) begin
        r_glitch <= 1'b1;
      end
      if (w_shift_en) begin
        r_shift <= {w_bit, r_shift[DATA_W-1:1]};
      end
      if (w_par_chk && (w_bit != f_parity(r_shift, r_par_odd))) begin
        r_par_pend <= 1'b1;
      end
      if ((w_stop1_chk || w_stop2_chk) && !w_bit) begin
        r_frm_pend <= 1'b1;
      end
      if ((w_shift_en || w_par_chk || w_stop1_chk) && w_bit) begin
        r_brk_pend <= 1'b0;
      end
    end
  end

  assign w_frm_final = r_frm_pend | ~w_bit;
  assign w_brk_final = (r_state == S_STOP1) ? (r_brk_pend & ~w_bit) : r_brk_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_brk      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= w_complete;
      r_busy     <= (w_next != S_IDLE);
      if (w_complete) begin
        r_rx_data <= r_shift;
        r_par_err <= r_par_pend;
        r_frm_err <= w_frm_final;
        r_brk     <= w_brk_final;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign par_err  = r_par_err;
  assign frm_err  = r_frm_err;
  assign brk      = r_brk;
  assign busy     = r_busy;

endmodule
